// File: rtl/instr_register_pipe_if.sv
// Bus bundle for instr_register_pipe: write request, read request and read-back data.
interface instr_register_pipe_if #(
  parameter int DEPTH = 32,
  parameter int OP_W  = 32
);
  localparam int AW    = $clog2(DEPTH);
  localparam int RES_W = 2 * OP_W;

  logic                    load_en;
  logic [AW-1:0]           write_pointer;
  logic [2:0]              opcode;
  logic signed [OP_W-1:0]  operand_a;
  logic signed [OP_W-1:0]  operand_b;
  logic                    read_en;
  logic [AW-1:0]           read_pointer;

  logic                    rd_valid;
  logic [2:0]              rd_opcode;
  logic signed [OP_W-1:0]  rd_operand_a;
  logic signed [OP_W-1:0]  rd_operand_b;
  logic signed [RES_W-1:0] rd_result;
  logic                    rd_err;
  logic                    rd_unwritten;
  logic [AW:0]             wr_count;

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b, read_en, read_pointer,
    input  rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err,
           rd_unwritten, wr_count
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b, read_en, read_pointer,
    output rd_valid, rd_opcode, rd_operand_a, rd_operand_b, rd_result, rd_err,
           rd_unwritten, wr_count
  );
endinterface

// File: rtl/instr_register_pipe.sv
// Instruction register file with a one-stage write pipeline (S1) that computes
// the ALU result before commit, a registered read port with S1 bypass, and a
// count of distinct entries written since reset.
module instr_register_pipe #(
  parameter int DEPTH = 32,
  parameter int OP_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_register_pipe_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int RES_W = 2 * OP_W;

  typedef enum logic [2:0] {
    OP_ZERO  = 3'd0,
    OP_PASSA = 3'd1,
    OP_PASSB = 3'd2,
    OP_ADD   = 3'd3,
    OP_SUB   = 3'd4,
    OP_MULT  = 3'd5,
    OP_DIV   = 3'd6,
    OP_MOD   = 3'd7
  } opcode_e;

  // S1 write stage
  logic                   s1_valid_q, s1_valid_d;
  logic [AW-1:0]          s1_addr_q,  s1_addr_d;
  opcode_e                s1_op_q,    s1_op_d;
  logic signed [OP_W-1:0] s1_a_q,     s1_a_d;
  logic signed [OP_W-1:0] s1_b_q,     s1_b_d;

  // S1 computed result
  logic signed [RES_W-1:0] a_ext, b_ext, s1_result;
  logic                    s1_err;

  // Storage
  logic [2:0]              mem_op_q  [DEPTH];
  logic signed [OP_W-1:0]  mem_a_q   [DEPTH];
  logic signed [OP_W-1:0]  mem_b_q   [DEPTH];
  logic signed [RES_W-1:0] mem_res_q [DEPTH];
  logic                    mem_err_q [DEPTH];
  logic [DEPTH-1:0]        written_q, written_d;
  logic [AW:0]             wr_count_q, wr_count_d;

  // Read port registers
  logic                    rd_valid_q,     rd_valid_d;
  logic [2:0]              rd_opcode_q,    rd_opcode_d;
  logic signed [OP_W-1:0]  rd_a_q,         rd_a_d;
  logic signed [OP_W-1:0]  rd_b_q,         rd_b_d;
  logic signed [RES_W-1:0] rd_result_q,    rd_result_d;
  logic                    rd_err_q,       rd_err_d;
  logic                    rd_unwritten_q, rd_unwritten_d;

  logic bypass_hit;

  assign a_ext = {{OP_W{s1_a_q[OP_W-1]}}, s1_a_q};
  assign b_ext = {{OP_W{s1_b_q[OP_W-1]}}, s1_b_q};
  assign bypass_hit = s1_valid_q && (s1_addr_q == bus.read_pointer);

  // Capture a new write request into S1; an idle cycle only drops the valid bit
  always_comb begin
    s1_valid_d = bus.load_en;
    s1_addr_d  = s1_addr_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (bus.load_en) begin
      s1_addr_d = bus.write_pointer;
      s1_op_d   = opcode_e'(bus.opcode);
      s1_a_d    = bus.operand_a;
      s1_b_d    = bus.operand_b;
    end
  end

  // ALU on the S1 instruction, operands widened first so no case can overflow
  always_comb begin
    s1_result = '0;
    s1_err    = 1'b0;
    case (s1_op_q)
      OP_ZERO:  s1_result = '0;
      OP_PASSA: s1_result = a_ext;
      OP_PASSB: s1_result = b_ext;
      OP_ADD:   s1_result = a_ext + b_ext;
      OP_SUB:   s1_result = a_ext - b_ext;
      OP_MULT:  s1_result = a_ext * b_ext;
      OP_DIV: begin
        if (b_ext == '0) s1_err = 1'b1;
        else             s1_result = a_ext / b_ext;
      end
      OP_MOD: begin
        if (b_ext == '0) s1_err = 1'b1;
        else             s1_result = a_ext % b_ext;
      end
    endcase
  end

  // Commit bookkeeping: mark the entry written and count first-time writes
  always_comb begin
    written_d  = written_q;
    wr_count_d = wr_count_q;
    if (s1_valid_q) begin
      written_d[s1_addr_q] = 1'b1;
      if (!written_q[s1_addr_q] && (wr_count_q != (AW+1)'(DEPTH))) begin
        wr_count_d = wr_count_q + (AW+1)'(1);
      end
    end
  end

  // Read selection: S1 bypass, then stored entry, then zeros for unwritten entries
  always_comb begin
    rd_valid_d     = bus.read_en;
    rd_opcode_d    = rd_opcode_q;
    rd_a_d         = rd_a_q;
    rd_b_d         = rd_b_q;
    rd_result_d    = rd_result_q;
    rd_err_d       = rd_err_q;
    rd_unwritten_d = rd_unwritten_q;
    if (bus.read_en) begin
      if (bypass_hit) begin
        rd_opcode_d    = s1_op_q;
        rd_a_d         = s1_a_q;
        rd_b_d         = s1_b_q;
        rd_result_d    = s1_result;
        rd_err_d       = s1_err;
        rd_unwritten_d = 1'b0;
      end else if (written_q[bus.read_pointer]) begin
        rd_opcode_d    = mem_op_q[bus.read_pointer];
        rd_a_d         = mem_a_q[bus.read_pointer];
        rd_b_d         = mem_b_q[bus.read_pointer];
        rd_result_d    = mem_res_q[bus.read_pointer];
        rd_err_d       = mem_err_q[bus.read_pointer];
        rd_unwritten_d = 1'b0;
      end else begin
        rd_opcode_d    = '0;
        rd_a_d         = '0;
        rd_b_d         = '0;
        rd_result_d    = '0;
        rd_err_d       = 1'b0;
        rd_unwritten_d = 1'b1;
      end
    end
  end

  // Control and read registers; reset discards any write still sitting in S1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q     <= 1'b0;
      s1_addr_q      <= '0;
      s1_op_q        <= OP_ZERO;
      s1_a_q         <= '0;
      s1_b_q         <= '0;
      written_q      <= '0;
      wr_count_q     <= '0;
      rd_valid_q     <= 1'b0;
      rd_opcode_q    <= '0;
      rd_a_q         <= '0;
      rd_b_q         <= '0;
      rd_result_q    <= '0;
      rd_err_q       <= 1'b0;
      rd_unwritten_q <= 1'b0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_addr_q      <= s1_addr_d;
      s1_op_q        <= s1_op_d;
      s1_a_q         <= s1_a_d;
      s1_b_q         <= s1_b_d;
      written_q      <= written_d;
      wr_count_q     <= wr_count_d;
      rd_valid_q     <= rd_valid_d;
      rd_opcode_q    <= rd_opcode_d;
      rd_a_q         <= rd_a_d;
      rd_b_q         <= rd_b_d;
      rd_result_q    <= rd_result_d;
      rd_err_q       <= rd_err_d;
      rd_unwritten_q <= rd_unwritten_d;
    end
  end

  // Entry storage is not reset; the written bits gate its visibility
  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      mem_op_q[s1_addr_q]  <= s1_op_q;
      mem_a_q[s1_addr_q]   <= s1_a_q;
      mem_b_q[s1_addr_q]   <= s1_b_q;
      mem_res_q[s1_addr_q] <= s1_result;
      mem_err_q[s1_addr_q] <= s1_err;
    end
  end

  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_opcode    = rd_opcode_q;
  assign bus.rd_operand_a = rd_a_q;
  assign bus.rd_operand_b = rd_b_q;
  assign bus.rd_result    = rd_result_q;
  assign bus.rd_err       = rd_err_q;
  assign bus.rd_unwritten = rd_unwritten_q;
  assign bus.wr_count     = wr_count_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Self-checking bench for instr_register_pipe: directed literal scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_register_pipe;
  localparam int DEPTH = 4;
  localparam int OP_W  = 8;
  localparam int AW    = 2;
  localparam int RES_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  bit   check_en = 1'b0;

  int num_checks = 0;
  int num_errors = 0;

  instr_register_pipe_if #(.DEPTH(DEPTH), .OP_W(OP_W)) bus ();

  instr_register_pipe #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Model state
  int      m_op  [DEPTH];
  int      m_a   [DEPTH];
  int      m_b   [DEPTH];
  longint  m_res [DEPTH];
  bit      m_err [DEPTH];
  bit      m_written [DEPTH];
  int      m_count = 0;
  bit      pend_valid = 0;
  int      pend_addr = 0, pend_op = 0, pend_a = 0, pend_b = 0;

  bit      exp_valid = 0;
  int      exp_op = 0, exp_a = 0, exp_b = 0;
  longint  exp_res = 0;
  bit      exp_err = 0, exp_unw = 0;

  // Instruction semantics in plain integer arithmetic, truncated to RES_W bits
  function automatic longint model_result(input int op, input int a, input int b,
                                          output bit err);
    longint r;
    logic signed [RES_W-1:0] t;
    err = 0;
    case (op)
      1: r = a;
      2: r = b;
      3: r = longint'(a) + longint'(b);
      4: r = longint'(a) - longint'(b);
      5: r = longint'(a) * longint'(b);
      6: if (b == 0) begin r = 0; err = 1; end else r = a / b;
      7: if (b == 0) begin r = 0; err = 1; end else r = a % b;
      default: r = 0;
    endcase
    t = r[RES_W-1:0];
    return longint'(t);
  endfunction

  // Behavioural model: reads see state before this edge, then pending commits,
  // then the newly requested write becomes pending
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) m_written[i] = 0;
      m_count = 0; pend_valid = 0;
      exp_valid = 0; exp_op = 0; exp_a = 0; exp_b = 0; exp_res = 0;
      exp_err = 0; exp_unw = 0;
    end else begin
      if (bus.read_en) begin
        int rp;
        bit e;
        rp = int'(bus.read_pointer);
        exp_valid = 1;
        if (pend_valid && pend_addr == rp) begin
          exp_op = pend_op; exp_a = pend_a; exp_b = pend_b;
          exp_res = model_result(pend_op, pend_a, pend_b, e);
          exp_err = e; exp_unw = 0;
        end else if (m_written[rp]) begin
          exp_op = m_op[rp]; exp_a = m_a[rp]; exp_b = m_b[rp];
          exp_res = m_res[rp]; exp_err = m_err[rp]; exp_unw = 0;
        end else begin
          exp_op = 0; exp_a = 0; exp_b = 0; exp_res = 0; exp_err = 0; exp_unw = 1;
        end
      end else begin
        exp_valid = 0;
      end
      if (pend_valid) begin
        bit e;
        if (!m_written[pend_addr] && m_count < DEPTH) m_count++;
        m_written[pend_addr] = 1;
        m_op[pend_addr] = pend_op; m_a[pend_addr] = pend_a; m_b[pend_addr] = pend_b;
        m_res[pend_addr] = model_result(pend_op, pend_a, pend_b, e);
        m_err[pend_addr] = e;
      end
      pend_valid = bus.load_en;
      pend_addr  = int'(bus.write_pointer);
      pend_op    = int'(bus.opcode);
      pend_a     = int'(bus.operand_a);
      pend_b     = int'(bus.operand_b);
    end
  end

  task automatic cmp(input string name, input longint actual, input longint expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      cmp("model rd_valid",     longint'(bus.rd_valid),     longint'(exp_valid));
      cmp("model rd_opcode",    longint'(bus.rd_opcode),    longint'(exp_op));
      cmp("model rd_operand_a", longint'(bus.rd_operand_a), longint'(exp_a));
      cmp("model rd_operand_b", longint'(bus.rd_operand_b), longint'(exp_b));
      cmp("model rd_result",    longint'(bus.rd_result),    exp_res);
      cmp("model rd_err",       longint'(bus.rd_err),       longint'(exp_err));
      cmp("model rd_unwritten", longint'(bus.rd_unwritten), longint'(exp_unw));
      cmp("model wr_count",     longint'(bus.wr_count),     longint'(m_count));
    end
  end

  // Drive one cycle of stimulus, sampled at the following rising edge
  task automatic applyStimulus(input bit ld, input int wp, input int op, input int a,
                               input int b, input bit rd, input int rp);
    @(negedge clk);
    bus.load_en       = ld;
    bus.write_pointer = AW'(wp);
    bus.opcode        = 3'(op);
    bus.operand_a     = OP_W'(a);
    bus.operand_b     = OP_W'(b);
    bus.read_en       = rd;
    bus.read_pointer  = AW'(rp);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Literal expectations, independent of the model
  task automatic checkOutput(input string tag, input bit v, input int op, input int a,
                             input int b, input longint res, input bit err,
                             input bit unw, input int cnt);
    cmp({tag, " rd_valid"},     longint'(bus.rd_valid),     longint'(v));
    cmp({tag, " rd_opcode"},    longint'(bus.rd_opcode),    longint'(op));
    cmp({tag, " rd_operand_a"}, longint'(bus.rd_operand_a), longint'(a));
    cmp({tag, " rd_operand_b"}, longint'(bus.rd_operand_b), longint'(b));
    cmp({tag, " rd_result"},    longint'(bus.rd_result),    res);
    cmp({tag, " rd_err"},       longint'(bus.rd_err),       longint'(err));
    cmp({tag, " rd_unwritten"}, longint'(bus.rd_unwritten), longint'(unw));
    cmp({tag, " wr_count"},     longint'(bus.wr_count),     longint'(cnt));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.load_en = 0; bus.write_pointer = '0; bus.opcode = '0;
    bus.operand_a = '0; bus.operand_b = '0; bus.read_en = 0; bus.read_pointer = '0;
    #2 reset_n = 1'b0;
    #1 check_en = 1'b1;
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Unwritten read right after reset
    applyStimulus(0, 0, 0, 0, 0, 1, 2);
    idle();
    checkOutput("unwritten", 1, 0, 0, 0, 0, 0, 1, 0);

    // MULT -7 * 9
    applyStimulus(1, 1, 5, -7, 9, 0, 0);
    idle();
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idle();
    checkOutput("mult", 1, 5, -7, 9, -63, 0, 0, 1);

    // DIV, MOD, divide by zero
    applyStimulus(1, 3, 6, -7, 2, 0, 0);
    applyStimulus(1, 0, 7, -7, 2, 0, 0);
    applyStimulus(1, 2, 6, 5, 0, 0, 0);
    idle();
    applyStimulus(0, 0, 0, 0, 0, 1, 3);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("div", 1, 6, -7, 2, -3, 0, 0, 4);
    applyStimulus(0, 0, 0, 0, 0, 1, 2);
    checkOutput("mod", 1, 7, -7, 2, -1, 0, 0, 4);
    idle();
    checkOutput("divzero", 1, 6, 5, 0, 0, 1, 0, 4);

    // Same-edge write/read returns prior contents, next edge bypasses S1
    applyStimulus(1, 2, 3, 100, 100, 1, 2);
    applyStimulus(0, 0, 0, 0, 0, 1, 2);
    checkOutput("same-edge", 1, 6, 5, 0, 0, 1, 0, 4);
    idle();
    checkOutput("bypass", 1, 3, 100, 100, 200, 0, 0, 4);

    // Overwrite keeps the count saturated, outputs hold without read_en
    applyStimulus(1, 0, 1, 12, 3, 0, 0);
    idle();
    idle();
    checkOutput("overwrite", 0, 3, 100, 100, 200, 0, 0, 4);

    // Reset while a write sits in S1: it must never commit
    applyStimulus(1, 1, 3, 1, 1, 0, 0);
    idle();
    #2 reset_n = 1'b0;
    #1 checkOutput("async reset", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    idle();
    checkOutput("discard", 1, 0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 600; i++) begin
      int a, b;
      a = int'($urandom_range(0, 255)) - 128;
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
      applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
                    int'($urandom_range(0, 7)), a, b,
                    bit'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)));
      if (i == 300) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b1;
      end
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
